// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// State encoding is fixed so a checker can decode the debug state port directly.
package adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The nibble index needs at least one bit even when there is only one nibble.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry.sv
// 4-bit ripple-carry adder slice shared by the serial sequencer.
module ripple_carry
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[NIBBLE_W];
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit adder processes the operands
// a nibble per cycle, LSB first, with the carry held in c_q between nibbles.
module serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output state_t           dbg_state
);

  localparam int IDX_W = idx_width(NIBBLES);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE and out_valid only in DONE, so requests
  // never overlap and a result is held unchanged until out_ready takes it.

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] rca_a, rca_b, rca_sum;
  logic                rca_cout;
  int unsigned         bit_base;
  logic                last_nibble;

  assign bit_base    = NIBBLE_W * int'(idx_q);
  assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));
  assign rca_a       = a_q[bit_base +: NIBBLE_W];
  assign rca_b       = b_q[bit_base +: NIBBLE_W];

  ripple_carry u_rca (
    .a         (rca_a),
    .b         (rca_b),
    .carry_in  (c_q),
    .sum       (rca_sum),
    .carry_out (rca_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in here.
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          c_d      = sub ? 1'b1 : cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[bit_base +: NIBBLE_W] = rca_sum;
        c_d = rca_cout;
        if (last_nibble) begin
          carry_d = rca_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (rca_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a 4-nibble and a 1-nibble instance, directed vectors
// plus seeded random traffic, checked by a queue-based scoreboard.
module tb_serial_adder_ctrl;
  import adder_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        u4_in_valid, u4_in_ready, u4_sub, u4_cin, u4_out_valid, u4_out_ready;
  logic        u4_carry, u4_ovf;
  logic [15:0] u4_op_a, u4_op_b, u4_result;
  state_t      u4_dbg;

  logic        u1_in_valid, u1_in_ready, u1_sub, u1_cin, u1_out_valid, u1_out_ready;
  logic        u1_carry, u1_ovf;
  logic [3:0]  u1_op_a, u1_op_b, u1_result;
  state_t      u1_dbg;

  serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .op_a(u4_op_a), .op_b(u4_op_b), .sub(u4_sub), .cin(u4_cin),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .result(u4_result),
    .carry_out(u4_carry), .overflow(u4_ovf), .dbg_state(u4_dbg)
  );

  serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .op_a(u1_op_a), .op_b(u1_op_b), .sub(u1_sub), .cin(u1_cin),
    .out_valid(u1_out_valid), .out_ready(u1_out_ready), .result(u1_result),
    .carry_out(u1_carry), .overflow(u1_ovf), .dbg_state(u1_dbg)
  );

  // ---------------- scoreboard ----------------
  // Entries are {result, carry_out, overflow}.
  logic [17:0] exp4_q[$];
  logic [5:0]  exp1_q[$];
  logic [17:0] e4;
  logic [5:0]  e1;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain full-width arithmetic, A - B taken as A + ~B + 1.
  function automatic logic [17:0] model4(input logic [15:0] a, b, input logic s, c);
    logic [15:0] be;
    logic [16:0] t;
    logic        ov;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {16'd0, (s ? 1'b1 : c)};
    ov = (a[15] == be[15]) && (t[15] != a[15]);
    return {t[15:0], t[16], ov};
  endfunction

  function automatic logic [5:0] model1(input logic [3:0] a, b, input logic s, c);
    logic [3:0] be;
    logic [4:0] t;
    logic       ov;
    be = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {4'd0, (s ? 1'b1 : c)};
    ov = (a[3] == be[3]) && (t[3] != a[3]);
    return {t[3:0], t[4], ov};
  endfunction

  // Monitor: a result is consumed on the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && u4_out_valid && u4_out_ready) begin
      if (exp4_q.size() == 0) begin
        check("u4 unexpected output", 32'(u4_result), 32'hDEAD_BEEF);
      end else begin
        e4 = exp4_q.pop_front();
        check("u4 result", 32'(u4_result), 32'(e4[17:2]));
        check("u4 carry_out", 32'(u4_carry), 32'(e4[1]));
        check("u4 overflow", 32'(u4_ovf), 32'(e4[0]));
      end
    end
    if (rst_n && u1_out_valid && u1_out_ready) begin
      if (exp1_q.size() == 0) begin
        check("u1 unexpected output", 32'(u1_result), 32'hDEAD_BEEF);
      end else begin
        e1 = exp1_q.pop_front();
        check("u1 result", 32'(u1_result), 32'(e1[5:2]));
        check("u1 carry_out", 32'(u1_carry), 32'(e1[1]));
        check("u1 overflow", 32'(u1_ovf), 32'(e1[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; tasks return at that same phase.
  task automatic issue4(input logic [15:0] a, b, input logic s, c, input logic [17:0] exp);
    int t = 0;
    while (!u4_in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("u4 in_ready timeout", 32'(u4_in_ready), 32'd1);
    u4_op_a = a; u4_op_b = b; u4_sub = s; u4_cin = c; u4_in_valid = 1'b1;
    @(posedge clk);
    exp4_q.push_back(exp);
    #1;
    u4_in_valid = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] a, b, input logic s, c, input logic [5:0] exp);
    int t = 0;
    while (!u1_in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("u1 in_ready timeout", 32'(u1_in_ready), 32'd1);
    u1_op_a = a; u1_op_b = b; u1_sub = s; u1_cin = c; u1_in_valid = 1'b1;
    @(posedge clk);
    exp1_q.push_back(exp);
    #1;
    u1_in_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_valid4(output int edges);
    edges = 1;
    while (!u4_out_valid && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic wait_valid1(output int edges);
    edges = 1;
    while (!u1_out_valid && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic drain(input int max_cycles);
    int t = 0;
    while ((exp4_q.size() != 0 || exp1_q.size() != 0) && t < max_cycles) begin
      @(posedge clk); #1; t++;
    end
    check("scoreboard pending", 32'(exp4_q.size() + exp1_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic [3:0]  sa, sb;
    logic        rs, rc;

    u4_in_valid = 0; u4_op_a = '0; u4_op_b = '0; u4_sub = 0; u4_cin = 0; u4_out_ready = 1;
    u1_in_valid = 0; u1_op_a = '0; u1_op_b = '0; u1_sub = 0; u1_cin = 0; u1_out_ready = 1;

    #12;
    check("reset in_ready", 32'(u4_in_ready), 32'd1);
    check("reset out_valid", 32'(u4_out_valid), 32'd0);
    check("reset result", 32'(u4_result), 32'd0);
    check("reset carry_out", 32'(u4_carry), 32'd0);
    check("reset overflow", 32'(u4_ovf), 32'd0);
    check("reset state", 32'(u4_dbg), 32'(IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add and latency
    issue4(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0});
    wait_valid4(lat);
    check("u4 latency edges", 32'(lat), 32'd5);
    drain(20);

    // Carry ripples through every nibble; signed overflow via cin
    issue4(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    issue4(16'h7FFF, 16'h0000, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1});
    // Subtraction, cin ignored
    issue4(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    issue4(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1});
    drain(40);

    // Backpressure: result held, no capture while DONE
    u4_out_ready = 1'b0;
    issue4(16'h00FF, 16'h0F01, 1'b0, 1'b0, {16'h1000, 1'b0, 1'b0});
    wait_valid4(lat);
    for (int i = 0; i < 10; i++) begin
      u4_op_a = 16'h0100 + 16'(i); u4_op_b = 16'h0002; u4_sub = 0; u4_cin = 0;
      u4_in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp result held", 32'(u4_result), 32'h1000);
      check("bp in_ready low", 32'(u4_in_ready), 32'd0);
      check("bp out_valid held", 32'(u4_out_valid), 32'd1);
    end
    exp4_q.push_back({16'h010B, 1'b0, 1'b0});
    u4_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp in_ready after release", 32'(u4_in_ready), 32'd1);
    @(posedge clk); #1;
    u4_in_valid = 1'b0;
    check("bp new op accepted", 32'(u4_dbg), 32'(RUN));
    drain(20);

    // Asynchronous reset while the third nibble is pending
    u4_op_a = 16'h1234; u4_op_b = 16'h4321; u4_sub = 0; u4_cin = 0; u4_in_valid = 1'b1;
    @(posedge clk); #1;
    u4_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid-run state", 32'(u4_dbg), 32'(RUN));
    check("mid-run partial result", 32'(u4_result), 32'h0055);
    #1 rst_n = 1'b0;
    #1;
    check("async reset state", 32'(u4_dbg), 32'(IDLE));
    check("async reset in_ready", 32'(u4_in_ready), 32'd1);
    check("async reset out_valid", 32'(u4_out_valid), 32'd0);
    check("async reset result", 32'(u4_result), 32'd0);
    check("async reset carry_out", 32'(u4_carry), 32'd0);
    check("async reset overflow", 32'(u4_ovf), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue4(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 1'b0, 1'b0});
    drain(20);

    // Single-nibble instance
    issue1(4'hF, 4'h1, 1'b0, 1'b0, {4'h0, 1'b1, 1'b0});
    wait_valid1(lat);
    check("u1 latency edges", 32'(lat), 32'd2);
    issue1(4'h3, 4'h5, 1'b1, 1'b0, {4'hE, 1'b0, 1'b0});
    issue1(4'h7, 4'h1, 1'b0, 1'b0, {4'h8, 1'b0, 1'b1});
    drain(20);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      issue4(ra, rb, rs, rc, model4(ra, rb, rs, rc));
    end
    drain(40);
    for (int i = 0; i < 1500; i++) begin
      sa = 4'($urandom_range(0, 15));
      sb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      issue1(sa, sb, rs, rc, model1(sa, sb, rs, rc));
    end
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
